// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CHECK   = 3'd2,
        RELEASE = 3'd3,
        RUN     = 3'd4,
        ERROR   = 3'd5
    } state_t;

    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot loader: streams program words into instruction memory, verifies an XOR
// checksum, then releases the core from reset after a settle delay.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int          DEPTH_WORDS   = 64,
    parameter int          SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        imem_wr_en,
    output logic [31:0] imem_wr_addr,
    output logic [31:0] imem_wr_data,
    output logic        core_reset,
    output logic        done,
    output logic        error,
    output logic [7:0]  word_count
);

    generate
        if (DEPTH_WORDS < 1 || DEPTH_WORDS > 255) begin : g_bad_depth
            $error("imem_boot_loader: DEPTH_WORDS must be in 1..255");
        end
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
            $error("imem_boot_loader: SETTLE_CYCLES must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] LAST_IDX   = 8'(DEPTH_WORDS - 1);
    localparam logic [7:0] SETTLE_INI = 8'(SETTLE_CYCLES - 1);

    state_t      state, state_n;
    logic [31:0] checksum;
    logic [7:0]  settle_cnt;
    logic        xfer;
    logic        restart;

    assign xfer    = load_valid && load_ready;
    assign restart = start && (state == IDLE || state == RUN || state == ERROR);

    always_comb begin
        state_n    = state;
        load_ready = (state == LOAD) || (state == CHECK);
        core_reset = (state != RUN);
        done       = (state == RUN);
        error      = (state == ERROR);
        case (state)
            IDLE:    if (start) state_n = LOAD;
            LOAD: begin
                // start is ignored here; only a transfer moves the FSM on
                if (xfer) begin
                    if (load_last)                   state_n = CHECK;
                    else if (word_count == LAST_IDX) state_n = ERROR;
                end
            end
            CHECK:   if (xfer) state_n = (load_data == checksum) ? RELEASE : ERROR;
            RELEASE: if (settle_cnt == 8'd0) state_n = RUN;
            RUN:     if (start) state_n = LOAD;
            ERROR:   if (start) state_n = LOAD;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= 32'd0;
            imem_wr_data <= 32'd0;
            word_count   <= 8'd0;
            checksum     <= 32'd0;
            settle_cnt   <= 8'd0;
        end else begin
            state      <= state_n;
            imem_wr_en <= 1'b0;
            if (restart) begin
                word_count <= 8'd0;
                checksum   <= 32'd0;
                settle_cnt <= 8'd0;
            end
            if (state == LOAD && xfer) begin
                imem_wr_en   <= 1'b1;
                imem_wr_addr <= BASE_ADDR + 32'(word_count) * WORD_BYTES;
                imem_wr_data <= load_data;
                word_count   <= word_count + 8'd1;
                checksum     <= checksum ^ load_data;
            end
            if (state == CHECK && xfer && load_data == checksum)
                settle_cnt <= SETTLE_INI;
            if (state == RELEASE && settle_cnt != 8'd0)
                settle_cnt <= settle_cnt - 8'd1;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: normal load, bad checksum, overflow,
// gapped handshake, mid-load reset, and restart from RUN on a second base address.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset, start, load_valid, load_last, sel;
    logic [31:0] load_data;

    logic        a_ready, a_wr_en, a_core_reset, a_done, a_error;
    logic [31:0] a_wr_addr, a_wr_data;
    logic [7:0]  a_wc;
    logic        b_ready, b_wr_en, b_core_reset, b_done, b_error;
    logic [31:0] b_wr_addr, b_wr_data;
    logic [7:0]  b_wc;

    logic        ready, wr_en, core_reset, done, error;
    logic [31:0] wr_addr, wr_data;
    logic [7:0]  wc;

    int nvec = 0;
    int nerr = 0;

    localparam logic [31:0] W0 = 32'h0000_0013;
    localparam logic [31:0] W1 = 32'h0010_0093;
    localparam logic [31:0] W2 = 32'h0020_8113;

    always #5 clk = ~clk;

    imem_boot_loader #(.BASE_ADDR(32'h0), .DEPTH_WORDS(4), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start & ~sel), .load_valid(load_valid & ~sel),
        .load_data(load_data), .load_last(load_last), .load_ready(a_ready),
        .imem_wr_en(a_wr_en), .imem_wr_addr(a_wr_addr), .imem_wr_data(a_wr_data),
        .core_reset(a_core_reset), .done(a_done), .error(a_error), .word_count(a_wc));

    imem_boot_loader #(.BASE_ADDR(32'h100), .DEPTH_WORDS(64), .SETTLE_CYCLES(4)) dut_b (
        .clk(clk), .reset(reset), .start(start & sel), .load_valid(load_valid & sel),
        .load_data(load_data), .load_last(load_last), .load_ready(b_ready),
        .imem_wr_en(b_wr_en), .imem_wr_addr(b_wr_addr), .imem_wr_data(b_wr_data),
        .core_reset(b_core_reset), .done(b_done), .error(b_error), .word_count(b_wc));

    assign ready      = sel ? b_ready      : a_ready;
    assign wr_en      = sel ? b_wr_en      : a_wr_en;
    assign wr_addr    = sel ? b_wr_addr    : a_wr_addr;
    assign wr_data    = sel ? b_wr_data    : a_wr_data;
    assign core_reset = sel ? b_core_reset : a_core_reset;
    assign done       = sel ? b_done       : a_done;
    assign error      = sel ? b_error      : a_error;
    assign wc         = sel ? b_wc         : a_wc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    // Present one word at negedge; it transfers on the following posedge.
    task automatic xfer(input logic [31:0] d, input logic last,
                        input logic [31:0] exp_addr, input logic exp_wr);
        @(negedge clk);
        load_valid = 1'b1; load_data = d; load_last = last;
        chk("load_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        load_valid = 1'b0; load_last = 1'b0;
        chk("wr_en", 32'(wr_en), 32'(exp_wr));
        if (exp_wr) begin
            chk("wr_addr", wr_addr, exp_addr);
            chk("wr_data", wr_data, d);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        chk("no_write", 32'(wr_en), 32'd0);
    endtask

    // Full 3-word load plus good checksum; core must leave reset 4 cycles later.
    task automatic good_load(input logic [31:0] base);
        pulse_start();
        chk("core_reset_loading", 32'(core_reset), 32'd1);
        xfer(W0, 1'b0, base,          1'b1);
        xfer(W1, 1'b0, base + 32'h4,  1'b1);
        xfer(W2, 1'b1, base + 32'h8,  1'b1);
        chk("word_count3", 32'(wc), 32'd3);
        xfer(W0 ^ W1 ^ W2, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("settle_reset", 32'(core_reset), 32'd1);
            chk("settle_nowrite", 32'(wr_en), 32'd0);
        end
        @(posedge clk); #1;
        chk("run_core_reset", 32'(core_reset), 32'd0);
        chk("run_done", 32'(done), 32'd1);
        chk("run_ready", 32'(ready), 32'd0);
        chk("run_wc", 32'(wc), 32'd3);
    endtask

    initial begin
        sel = 1'b0; reset = 1'b1; start = 1'b0;
        load_valid = 1'b0; load_last = 1'b0; load_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_wc", 32'(wc), 32'd0);
        @(negedge clk); reset = 1'b0;

        // normal load
        good_load(32'h0);

        // restart from RUN, then bad checksum
        pulse_start();
        chk("restart_core_reset", 32'(core_reset), 32'd1);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_wc", 32'(wc), 32'd0);
        xfer(W0, 1'b0, 32'h0, 1'b1);
        xfer(W1, 1'b0, 32'h4, 1'b1);
        xfer(W2, 1'b1, 32'h8, 1'b1);
        xfer(32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
        chk("badsum_error", 32'(error), 32'd1);
        chk("badsum_core_reset", 32'(core_reset), 32'd1);
        chk("badsum_ready", 32'(ready), 32'd0);
        idle_cycle();
        chk("badsum_error_hold", 32'(error), 32'd1);

        // overflow at DEPTH_WORDS=4
        pulse_start();
        chk("ovf_error_clear", 32'(error), 32'd0);
        for (int i = 0; i < 4; i++)
            xfer(32'hA000_0000 + 32'(i), 1'b0, 32'(4 * i), 1'b1);
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_ready", 32'(ready), 32'd0);
        chk("ovf_wc", 32'(wc), 32'd4);
        idle_cycle();

        // gapped handshake
        pulse_start();
        xfer(32'h1111_1111, 1'b0, 32'h0, 1'b1);
        idle_cycle();
        xfer(32'h2222_2222, 1'b1, 32'h4, 1'b1);
        idle_cycle();
        chk("gap_wc", 32'(wc), 32'd2);

        // reset mid-load after two words, then recover
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); reset = 1'b0;
        pulse_start();
        xfer(W0, 1'b0, 32'h0, 1'b1);
        xfer(W1, 1'b0, 32'h4, 1'b1);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_wc", 32'(wc), 32'd0);
        chk("midrst_core_reset", 32'(core_reset), 32'd1);
        chk("midrst_wr_en", 32'(wr_en), 32'd0);
        @(negedge clk); reset = 1'b0;
        good_load(32'h0);

        // second instance at BASE_ADDR=0x100
        sel = 1'b1;
        good_load(32'h100);
        pulse_start();
        chk("b_restart_core_reset", 32'(core_reset), 32'd1);
        chk("b_restart_done", 32'(done), 32'd0);
        xfer(32'h0000_0013, 1'b1, 32'h100, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
